xor_parity_rx: RTL and testbench
================================

# xor_parity_rx

Serial receiver and checker for even-parity frames: collects DATA_W data bits LSB-first plus one parity bit, folds them through a running XOR, and presents the assembled word with a parity-error flag on a valid/ready output port. It is the receive-side counterpart of the team's XOR-based parity generation. It sits between a serial bit source and any word-level consumer.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (≥1)
- CNT_W, 8, width of saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_bit is valid this cycle
- in_bit  input  1  serial bit, LSB of data first, parity bit last
- in_ready  output  1  receiver can accept a bit this cycle
- out_valid  output  1  out_data/out_err hold a completed frame
- out_ready  input  1  consumer accepts the frame
- out_data  output  DATA_W  assembled data word
- out_err  output  1  1 = parity mismatch (XOR of data bits ^ parity bit = 1)
- err_count  output  CNT_W  number of frames with out_err=1, saturating

## Operation
- Bit accepted on a rising clk when in_valid & in_ready.
- States: RX_DATA, RX_PAR, RX_OUT.
  - RX_DATA: accepted bit written to data position bit_cnt; acc <= acc ^ in_bit; bit_cnt increments; after the DATA_W-th accepted bit → RX_PAR.
  - RX_PAR: accepted bit is parity; out_err <= acc ^ in_bit; out_data <= assembled word; → RX_OUT.
  - RX_OUT: out_valid=1; no bits accepted. On out_valid & out_ready → RX_DATA, bit_cnt=0, acc=0.
- err_count increments by 1 on entering RX_OUT with out_err=1; holds at 2^CNT_W−1 (no wrap).
- Cycles with in_valid=0 leave state, bit_cnt and acc unchanged (gaps allowed anywhere in a frame).
- in_bit ignored whenever in_valid & in_ready is false.

## Timing
- Reset (asynchronous, any time, including mid-frame or during RX_OUT): state=RX_DATA, bit_cnt=0, acc=0, in_ready=0, out_valid=0, out_data=0, out_err=0, err_count=0. A partial frame is discarded.
- in_ready is registered: 0 during reset; 1 from the first rising clk after rst_n deasserts; 0 in RX_OUT.
- Latency: out_valid rises on the clk edge that accepts the parity bit (visible next cycle); a frame takes a minimum of DATA_W+1 accepted bits and then at least 1 cycle in RX_OUT.
- in_ready falls on the same edge that out_valid rises; in_ready rises on the same edge that out_valid falls (the handshake edge). No bit is accepted in the handshake cycle itself.
- out_data/out_err stable while out_valid=1 and out_ready=0, for any duration.
- Max throughput: one frame per DATA_W+2 cycles.

## Structure
- Package xor_parity_pkg: state enum (RX_DATA, RX_PAR, RX_OUT), default DATA_W, and the bit_cnt width derived as $clog2(DATA_W+1).
- One sub-module, xor_sat_counter (CNT_W-bit saturating incrementer with async active-low reset), instantiated for err_count; everything else stays in xor_parity_rx.

## Test plan
- Good frame: DATA_W=8, bits 1,0,1,0,0,1,0,1 then parity 0, out_ready=1 → out_data=0xA5, out_err=0, err_count=0, out_valid high exactly 1 cycle.
- Bad frame: bits 1,0,0,0,0,0,0,0 then parity 0 → out_data=0x01, out_err=1, err_count=1.
- Backpressure and gaps: 0xFF with parity 0, in_valid deasserted for 3 cycles between bits 4 and 5, out_ready held low 5 cycles → in_ready=0, out_data=0xFF and out_err=0 stable through the stall; the next frame is accepted only after the handshake.
- Reset mid-frame: rst_n pulsed low after 4 bits, then full frame 0x3C with parity 0 → all outputs 0 during reset; single result 0x3C, out_err=0.
- Saturation: CNT_W=8, 260 consecutive bad frames → err_count reaches 255 and holds; the next good frame leaves it at 255.

Source files
------------

// File: rtl/xor_parity_pkg.sv
// Shared types and sizing helpers for the even-parity serial receiver.
package xor_parity_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;
   localparam int unsigned DEFAULT_CNT_W  = 8;

   typedef enum logic [1:0] {
      RX_DATA = 2'd0,
      RX_PAR  = 2'd1,
      RX_OUT  = 2'd2
   } rx_state_e;

   // bit_cnt must be able to hold DATA_W itself once the last data bit lands
   function automatic int unsigned bit_cnt_width(input int unsigned data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/xor_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module xor_sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/xor_parity_rx.sv
// Even-parity serial frame receiver: DATA_W bits LSB-first plus parity,
// presented as a word with a parity-error flag on a valid/ready port.
module xor_parity_rx
   import xor_parity_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_bit,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [CNT_W-1:0]  err_count
);

   localparam int unsigned BCW = bit_cnt_width(DATA_W);

   rx_state_e         state_q, state_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic              acc_q, acc_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_err_q, out_err_d;
   logic              accept_c;
   logic              handshake_c;
   logic              last_bit_c;
   logic              err_inc_c;

   assign accept_c    = in_valid & in_ready_q;
   assign handshake_c = out_valid_q & out_ready;
   assign last_bit_c  = (bit_cnt_q == BCW'(DATA_W - 1));

   // State register plus all registered datapath/outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RX_DATA;
         bit_cnt_q   <= '0;
         acc_q       <= 1'b0;
         data_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         acc_q       <= acc_d;
         data_q      <= data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_DATA: if (accept_c && last_bit_c) state_d = RX_PAR;
         RX_PAR:  if (accept_c)               state_d = RX_OUT;
         RX_OUT:  if (handshake_c)            state_d = RX_DATA;
         default:                             state_d = RX_DATA;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      acc_d      = acc_q;
      data_d     = data_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
      err_inc_c  = 1'b0;
      unique case (state_q)
         RX_DATA: begin
            if (accept_c) begin
               for (int unsigned i = 0; i < DATA_W; i++) begin
                  if (bit_cnt_q == BCW'(i)) data_d[i] = in_bit;
               end
               acc_d     = acc_q ^ in_bit;
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
         end
         RX_PAR: begin
            if (accept_c) begin
               out_data_d = data_q;
               out_err_d  = acc_q ^ in_bit;
               err_inc_c  = acc_q ^ in_bit;
            end
         end
         RX_OUT: begin
            if (handshake_c) begin
               bit_cnt_d = '0;
               acc_d     = 1'b0;
               data_d    = '0;
            end
         end
         default: begin
            bit_cnt_d = '0;
            acc_d     = 1'b0;
         end
      endcase
      in_ready_d  = (state_d != RX_OUT);
      out_valid_d = (state_d == RX_OUT);
   end

   xor_sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (err_inc_c),
      .count_o (err_count)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_xor_parity_rx.sv
// Directed self-checking bench for xor_parity_rx (DATA_W=8, CNT_W=8).
module tb_xor_parity_rx;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_bit;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err;
   logic [CNT_W-1:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   xor_parity_rx #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Step one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one bit until accepted, bounded
   task automatic send_bit(input logic b);
      logic taken;
      taken    = 1'b0;
      in_valid = 1'b1;
      in_bit   = b;
      for (int k = 0; k < 50 && !taken; k++) begin
         taken = in_ready;
         step();
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
      if (!taken) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_bit_timeout: in_ready stayed 0, required 1");
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic par);
      for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
      send_bit(par);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'h0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_out_data"},  32'(out_data),  32'h0);
      chk({tag, "_out_err"},   32'(out_err),   32'h0);
      chk({tag, "_err_count"}, 32'(err_count), 32'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      out_ready = 1'b1;

      // Reset state
      step();
      step();
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      chk("rel_in_ready_still0", 32'(in_ready), 32'h0);
      step();
      chk("rel_in_ready_1", 32'(in_ready), 32'h1);

      // Good frame 0xA5, parity 0
      send_frame(8'hA5, 1'b0);
      chk("good_valid",    32'(out_valid), 32'h1);
      chk("good_data",     32'(out_data),  32'hA5);
      chk("good_err",      32'(out_err),   32'h0);
      chk("good_cnt",      32'(err_count), 32'h0);
      chk("good_in_ready", 32'(in_ready),  32'h0);
      step();
      chk("good_valid_1cyc", 32'(out_valid), 32'h0);
      chk("good_ready_back", 32'(in_ready),  32'h1);

      // Bad frame 0x01, parity 0
      send_frame(8'h01, 1'b0);
      chk("bad_valid", 32'(out_valid), 32'h1);
      chk("bad_data",  32'(out_data),  32'h01);
      chk("bad_err",   32'(out_err),   32'h1);
      chk("bad_cnt",   32'(err_count), 32'h1);
      step();
      chk("bad_valid_drop", 32'(out_valid), 32'h0);

      // Backpressure and gaps: 0xFF parity 0, gap after bit 4, consumer stalls 5 cycles
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      for (int g = 0; g < 3; g++) begin
         in_valid = 1'b0;
         in_bit   = 1'b0;
         step();
      end
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      send_bit(1'b0);
      for (int s = 0; s < 5; s++) begin
         in_valid = 1'b1;
         in_bit   = 1'b1;
         chk("stall_valid",    32'(out_valid), 32'h1);
         chk("stall_in_ready", 32'(in_ready),  32'h0);
         chk("stall_data",     32'(out_data),  32'hFF);
         chk("stall_err",      32'(out_err),   32'h0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stall_hold_valid", 32'(out_valid), 32'h1);
      step();
      chk("hs_valid_drop", 32'(out_valid), 32'h0);
      chk("hs_in_ready",   32'(in_ready),  32'h1);
      chk("hs_cnt",        32'(err_count), 32'h1);
      // Next frame after the handshake: stall bits must not have leaked in
      send_frame(8'h5A, 1'b0);
      chk("post_stall_data", 32'(out_data), 32'h5A);
      chk("post_stall_err",  32'(out_err),  32'h0);
      step();

      // Reset mid-frame after 4 bits
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midrst");
      step();
      step();
      chk_zero_outputs("midrst_hold");
      rst_n = 1'b1;
      step();
      send_frame(8'h3C, 1'b0);
      chk("rst_frame_valid", 32'(out_valid), 32'h1);
      chk("rst_frame_data",  32'(out_data),  32'h3C);
      chk("rst_frame_err",   32'(out_err),   32'h0);
      chk("rst_frame_cnt",   32'(err_count), 32'h0);
      step();
      chk("rst_frame_single", 32'(out_valid), 32'h0);

      // Saturation: 260 bad frames from a cleared counter
      for (int f = 1; f <= 260; f++) begin
         send_frame(8'h01, 1'b0);
         chk("sat_cnt", 32'(err_count), (f > 255) ? 32'd255 : 32'(f));
         step();
      end
      send_frame(8'h00, 1'b0);
      chk("sat_good_err", 32'(out_err),   32'h0);
      chk("sat_good_cnt", 32'(err_count), 32'd255);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
